// File: rtl/phy_sym_pkg.sv
// Shared symbol constants, link state encoding and a width helper for the
// phy-layer serial transmit path.
package phy_sym_pkg;

    localparam logic [7:0] COM_SYM_8B  = 8'hBC;
    localparam logic [7:0] IDLE_SYM_8B = 8'h7C;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } link_state_t;

    // Bits needed to hold values 0..value-1, never less than one so that
    // counters sized from degenerate parameters still have a legal width.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Symbol shift register: parallel load with per-symbol tag bits, then one
// bit per cycle out of the configured end.
module serial_shift_reg #(
    parameter int DW        = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic          clk_32f,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] load_word,
    input  logic          load_idle,
    input  logic          load_com,
    output logic          data_out,
    output logic          idle_out,
    output logic          com_out
);

    logic [DW-1:0] shreg;

    // Load a new symbol and its tags at a boundary, otherwise shift one bit.
    // NOTE: the shift register is reset because data_out is driven straight
    // from it and must read 0 while reset is held.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            idle_out <= 1'b0;
            com_out  <= 1'b0;
        end else if (load) begin
            shreg    <= load_word;
            idle_out <= load_idle;
            com_out  <= load_com;
        end else if (MSB_FIRST != 0) begin
            shreg <= {shreg[DW-2:0], 1'b0};
        end else begin
            shreg <= {1'b0, shreg[DW-1:1]};
        end
    end

    assign data_out = (MSB_FIRST != 0) ? shreg[DW-1] : shreg[0];

endmodule

// File: rtl/paralelo_serial_param.sv
// Single-lane parallel-to-serial transmitter: initial COM burst, then data
// words, IDLE fill and periodic COM skip symbols on one bit-rate clock.
module paralelo_serial_param
    import phy_sym_pkg::*;
#(
    parameter int            DW         = 8,
    parameter logic [DW-1:0] COM_SYM    = DW'(COM_SYM_8B),
    parameter logic [DW-1:0] IDLE_SYM   = DW'(IDLE_SYM_8B),
    parameter int            COM_COUNT  = 2,
    parameter int            SKP_PERIOD = 4,
    parameter int            MSB_FIRST  = 1
) (
    input  logic          clk_32f,
    input  logic          reset,
    input  logic [DW-1:0] data_in,
    input  logic          valid_in,
    output logic          ready_out,
    output logic          data_out,
    output logic          symbol_start,
    output logic          sync_done,
    output logic          idle_out,
    output logic          com_out
);

    localparam int CNT_W = clog2(DW);
    localparam int COM_W = clog2(COM_COUNT + 1);
    localparam int SKP_W = clog2(SKP_PERIOD + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW - 1);
    localparam logic [COM_W-1:0] COM_LAST = COM_W'(COM_COUNT);
    localparam logic [SKP_W-1:0] SKP_LAST = SKP_W'(SKP_PERIOD);

    link_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [COM_W-1:0] com_cnt, com_cnt_nxt;
    logic [SKP_W-1:0] skp_cnt, skp_cnt_nxt;
    logic [DW-1:0]    load_word;
    logic             load_idle;
    logic             load_com;
    logic             boundary;
    logic             skp_due;

    assign boundary = (cnt == CNT_LAST);
    assign skp_due  = (SKP_PERIOD != 0) && (skp_cnt == SKP_LAST);

    // A word is taken only at a boundary where the next symbol is not
    // already claimed by the sync burst or a due skip COM.
    assign ready_out = boundary &&
                       (((state == SYNC) && (com_cnt == COM_LAST)) ||
                        ((state == ACTIVE) && !skp_due));

    assign symbol_start = (cnt == '0);
    assign sync_done    = (state == ACTIVE);

    // State, burst and skip counters; bit counter wraps at each boundary.
    // NOTE: non-blocking assignments keep every register updating from the
    // same pre-edge values, independent of statement order.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state   <= SYNC;
            cnt     <= CNT_LAST;
            com_cnt <= '0;
            skp_cnt <= '0;
        end else begin
            state   <= state_nxt;
            com_cnt <= com_cnt_nxt;
            skp_cnt <= skp_cnt_nxt;
            cnt     <= boundary ? '0 : cnt + CNT_W'(1);
        end
    end

    // Next-state and symbol selection, evaluated only at a boundary.
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        com_cnt_nxt = com_cnt;
        skp_cnt_nxt = skp_cnt;
        load_word   = IDLE_SYM;
        load_idle   = 1'b0;
        load_com    = 1'b0;
        if (boundary) begin
            if ((state == SYNC) && (com_cnt != COM_LAST)) begin
                load_word   = COM_SYM;
                load_com    = 1'b1;
                com_cnt_nxt = com_cnt + COM_W'(1);
            end else begin
                state_nxt = ACTIVE;
                if (skp_due) begin
                    load_word   = COM_SYM;
                    load_com    = 1'b1;
                    skp_cnt_nxt = '0;
                end else begin
                    if (valid_in) begin
                        load_word = data_in;
                    end else begin
                        load_word = IDLE_SYM;
                        load_idle = 1'b1;
                    end
                    // Saturates at the period; with insertion disabled it stays 0.
                    if (skp_cnt != SKP_LAST) skp_cnt_nxt = skp_cnt + SKP_W'(1);
                end
            end
        end
    end

    serial_shift_reg #(
        .DW        (DW),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .load      (boundary),
        .load_word (load_word),
        .load_idle (load_idle),
        .load_com  (load_com),
        .data_out  (data_out),
        .idle_out  (idle_out),
        .com_out   (com_out)
    );

endmodule

// File: tb/tb_paralelo_serial_param.sv
// Directed bench: default instance, skip insertion disabled, and LSB-first.
module tb_paralelo_serial_param;

    localparam int K_BIT  = 0;
    localparam int K_RDY  = 1;
    localparam int K_SS   = 2;
    localparam int K_COM  = 3;
    localparam int K_IDLE = 4;
    localparam int K_SYNC = 5;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic       valid_in;
    logic [7:0] data_in;

    wire [2:0] dout, rdy, ss, sd, idl, com;

    int   sel = 0;
    int   checks = 0;
    int   errors = 0;
    logic [5:0] cap [1:200];
    logic [7:0] words [0:31];

    logic m_bit, m_rdy, m_ss, m_com, m_idle, m_sync;
    assign m_bit  = dout[sel];
    assign m_rdy  = rdy[sel];
    assign m_ss   = ss[sel];
    assign m_com  = com[sel];
    assign m_idle = idl[sel];
    assign m_sync = sd[sel];

    always #5 clk_32f = ~clk_32f;

    paralelo_serial_param u_dut_a (
        .clk_32f (clk_32f), .reset (reset), .data_in (data_in), .valid_in (valid_in),
        .ready_out (rdy[0]), .data_out (dout[0]), .symbol_start (ss[0]),
        .sync_done (sd[0]), .idle_out (idl[0]), .com_out (com[0])
    );

    paralelo_serial_param #(.SKP_PERIOD (0)) u_dut_b (
        .clk_32f (clk_32f), .reset (reset), .data_in (data_in), .valid_in (valid_in),
        .ready_out (rdy[1]), .data_out (dout[1]), .symbol_start (ss[1]),
        .sync_done (sd[1]), .idle_out (idl[1]), .com_out (com[1])
    );

    paralelo_serial_param #(.MSB_FIRST (0)) u_dut_c (
        .clk_32f (clk_32f), .reset (reset), .data_in (data_in), .valid_in (valid_in),
        .ready_out (rdy[2]), .data_out (dout[2]), .symbol_start (ss[2]),
        .sync_done (sd[2]), .idle_out (idl[2]), .com_out (com[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int kind, input int first, input int last);
        logic [63:0] v;
        v = '0;
        for (int c = first; c <= last; c++) v = {v[62:0], cap[c][kind]};
        return v;
    endfunction

    // Reset released on a falling edge; the next rising edge is cycle 1.
    task automatic do_reset();
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (2) @(negedge clk_32f);
        reset = 1'b0;
    endtask

    // Upstream holds words[idx] until accepted; valid is dropped for the
    // single edge following cycle drop_cyc.
    task automatic run_stream(input int n, input int drop_cyc, input logic en);
        int   idx;
        logic acc;
        do_reset();
        idx      = 0;
        acc      = 1'b0;
        data_in  = words[0];
        valid_in = en && (drop_cyc != 0);
        for (int cyc = 1; cyc <= n; cyc++) begin
            @(negedge clk_32f);
            if (acc) begin
                idx++;
                data_in = words[idx];
            end
            valid_in = en && (cyc != drop_cyc);
            cap[cyc] = {m_sync, m_idle, m_com, m_ss, m_rdy, m_bit};
            acc      = m_rdy && valid_in;
        end
        valid_in = 1'b0;
    endtask

    initial begin
        int n_rdy, n_off, n_com;
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        #1;
        check("reset_outs", {m_bit, m_rdy, m_ss, m_com, m_idle, m_sync}, 6'd0);

        // Sync burst followed by IDLE fill.
        sel = 0;
        foreach (words[i]) words[i] = 8'hFF;
        run_stream(24, -1, 1'b0);
        check("t1_bits", pack(K_BIT, 1, 24), 24'hBCBC7C);
        check("t1_sstart", pack(K_SS, 1, 24), 24'h808080);
        check("t1_com", pack(K_COM, 1, 24), 24'hFFFF00);
        check("t1_idle", pack(K_IDLE, 1, 24), 24'h0000FF);
        check("t1_sync", pack(K_SYNC, 1, 24), 24'h0000FF);
        check("t1_ready", pack(K_RDY, 1, 24), 24'h000101);

        // Continuous words with a skip COM after four ACTIVE symbols.
        words[0] = 8'hFF; words[1] = 8'hEE; words[2] = 8'hDD;
        words[3] = 8'hCC; words[4] = 8'h88; words[5] = 8'h77;
        run_stream(64, -1, 1'b1);
        check("t2_bits", pack(K_BIT, 17, 64), 48'hFFEEDDCCBC88);
        check("t2_com", pack(K_COM, 17, 64), 48'h00000000FF00);
        check("t2_ready", pack(K_RDY, 1, 64), 64'h0001_0101_0100_0101);
        check("t2_ready48", cap[48][K_RDY], 1'b0);

        // One missed boundary inserts an IDLE that counts toward the period.
        run_stream(64, 24, 1'b1);
        check("t3_bits", pack(K_BIT, 17, 64), 48'hFF7CEEDDBCCC);
        check("t3_idle", pack(K_IDLE, 17, 64), 48'h00FF00000000);
        check("t3_com", pack(K_COM, 17, 64), 48'h00000000FF00);

        // Skip insertion disabled: 20 words, no COM after the burst.
        sel = 1;
        foreach (words[i]) words[i] = 8'h10 + 8'(i);
        run_stream(176, -1, 1'b1);
        n_rdy = 0; n_off = 0; n_com = 0;
        for (int c = 1; c <= 175; c++) begin
            if (cap[c][K_RDY]) begin
                n_rdy++;
                if (c % 8 != 0) n_off++;
            end
        end
        for (int c = 17; c <= 176; c++) if (cap[c][K_COM]) n_com++;
        check("t4_ready_cnt", n_rdy, 20);
        check("t4_ready_offgrid", n_off, 0);
        check("t4_com_cnt", n_com, 0);
        check("t4_bits", pack(K_BIT, 17, 32), 16'h1011);

        // Reset asserted at cnt == 3 of a data symbol.
        sel = 0;
        words[0] = 8'hFF; words[1] = 8'hEE;
        do_reset();
        valid_in = 1'b1;
        data_in  = 8'hFF;
        repeat (20) @(negedge clk_32f);
        check("t5_pre", {m_bit, m_sync}, 2'b11);
        #2 reset = 1'b1;
        #1 check("t5_reset_outs", {m_bit, m_rdy, m_ss, m_com, m_idle, m_sync}, 6'd0);
        run_stream(24, -1, 1'b1);
        check("t5_bits", pack(K_BIT, 1, 24), 24'hBCBCFF);
        check("t5_sync", pack(K_SYNC, 1, 24), 24'h0000FF);

        // LSB-first ordering.
        sel = 2;
        words[0] = 8'hA5; words[1] = 8'h01;
        run_stream(32, -1, 1'b1);
        check("t6_com_bits", pack(K_BIT, 1, 16), 16'h3D3D);
        check("t6_a5_bits", pack(K_BIT, 17, 24), 8'hA5);
        check("t6_01_bits", pack(K_BIT, 25, 32), 8'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
